vga_sync_generator: RTL and testbench

- Produces VGA 800x600 @ 72 Hz timing from the 50 MHz system clock: hsync, vsync, data-enable, pixel position, and line/frame start pulses.
- Sits directly upstream of the display position tracker, which rebuilds column/row from rising edges of hsync/vsync. Sync polarity therefore defaults to active-high.
- Also feeds the pixel/colour stage with a DE and position aligned to the syncs.

---
 rtl/vga_timing_pkg.sv | 55 +++++
 rtl/vga_axis_counter.sv | 65 ++++++
 rtl/vga_sync_generator.sv | 149 ++++++++++++++
 tb/tb_vga_sync_generator.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared VGA 800x600 @ 72 Hz timing constants (50 MHz pixel clock), the
// per-axis segment state type and small helpers. Used by the sync generator
// and by the downstream display position tracker so both agree on geometry.
// ---------------------------------------------------------------------------
package vga_timing_pkg;

    // Segments of one axis, visited in this order and then back to ACTIVE.
    typedef enum logic [1:0] {
        SEG_ACTIVE = 2'd0,
        SEG_FRONT  = 2'd1,
        SEG_SYNC   = 2'd2,
        SEG_BACK   = 2'd3
    } seg_state_t;

    // Horizontal geometry in pixel ticks.
    localparam int VGA_H_VISIBLE = 800;
    localparam int VGA_H_FRONT   = 56;
    localparam int VGA_H_SYNC    = 120;
    localparam int VGA_H_BACK    = 64;

    // Vertical geometry in lines.
    localparam int VGA_V_VISIBLE = 600;
    localparam int VGA_V_FRONT   = 37;
    localparam int VGA_V_SYNC    = 6;
    localparam int VGA_V_BACK    = 23;

    function automatic int axis_total(input int visible, input int front,
                                      input int sync, input int back);
        return visible + front + sync + back;
    endfunction

    function automatic seg_state_t seg_next(input seg_state_t s);
        seg_state_t n;
        n = SEG_ACTIVE;
        unique case (s)
            SEG_ACTIVE: n = SEG_FRONT;
            SEG_FRONT:  n = SEG_SYNC;
            SEG_SYNC:   n = SEG_BACK;
            SEG_BACK:   n = SEG_ACTIVE;
        endcase
        return n;
    endfunction

    localparam int VGA_H_TOTAL = axis_total(VGA_H_VISIBLE, VGA_H_FRONT, VGA_H_SYNC, VGA_H_BACK);
    localparam int VGA_V_TOTAL = axis_total(VGA_V_VISIBLE, VGA_V_FRONT, VGA_V_SYNC, VGA_V_BACK);

    // Inclusive sync windows in position units.
    localparam int VGA_H_SYNC_START = VGA_H_VISIBLE + VGA_H_FRONT;
    localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;
    localparam int VGA_V_SYNC_START = VGA_V_VISIBLE + VGA_V_FRONT;
    localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;

endpackage

// File: rtl/vga_axis_counter.sv
// ---------------------------------------------------------------------------
// vga_axis_counter
// One timing axis: a position counter 0..TOTAL-1 and a four-state segment
// FSM (ACTIVE -> FRONT -> SYNC -> BACK) with its own in-segment counter.
// Ports:
//   clock, reset  clock and asynchronous active-high reset
//   advance       step the axis by one position this clock
//   pos           current position
//   state         current segment
//   wrap          high on the advancing clock that leaves position TOTAL-1
// ---------------------------------------------------------------------------
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int VISIBLE = VGA_H_VISIBLE,
    parameter int FRONT   = VGA_H_FRONT,
    parameter int SYNC    = VGA_H_SYNC,
    parameter int BACK    = VGA_H_BACK,
    parameter int WIDTH   = 12
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             advance,
    output logic [WIDTH-1:0] pos,
    output seg_state_t       state,
    output logic             wrap
);

    localparam int               TOTAL    = axis_total(VISIBLE, FRONT, SYNC, BACK);
    localparam logic [WIDTH-1:0] LAST_POS = WIDTH'(TOTAL - 1);

    logic [WIDTH-1:0] seg_cnt;
    logic [WIDTH-1:0] seg_last;

    always_comb begin
        seg_last = WIDTH'(VISIBLE - 1);
        unique case (state)
            SEG_ACTIVE: seg_last = WIDTH'(VISIBLE - 1);
            SEG_FRONT:  seg_last = WIDTH'(FRONT - 1);
            SEG_SYNC:   seg_last = WIDTH'(SYNC - 1);
            SEG_BACK:   seg_last = WIDTH'(BACK - 1);
        endcase
    end

    assign wrap = advance && (pos == LAST_POS);

    // Segment lengths sum to TOTAL, so BACK ends on the same tick the
    // position wraps and the two counters never drift apart.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pos     <= '0;
            seg_cnt <= '0;
            state   <= SEG_ACTIVE;
        end else if (advance) begin
            pos <= wrap ? '0 : pos + WIDTH'(1);
            if (seg_cnt == seg_last) begin
                seg_cnt <= '0;
                state   <= seg_next(state);
            end else begin
                seg_cnt <= seg_cnt + WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/vga_sync_generator.sv
// ---------------------------------------------------------------------------
// vga_sync_generator
// VGA timing generator (default 800x600 @ 72 Hz from a 50 MHz clock).
// Ports:
//   clock        system clock
//   reset        asynchronous active-high reset
//   pix_en       pixel tick enable (tie high for one pixel per clock)
//   hsync/vsync  sync outputs, HSYNC_POL/VSYNC_POL when asserted
//   de           data enable, high inside the visible area
//   h_count      pixel column presented this tick
//   v_count      line presented this tick
//   line_start   one-clock pulse when h_count = 0 is presented
//   frame_start  one-clock pulse when (0,0) is presented
// All outputs are registered and come from the same internal position.
// ---------------------------------------------------------------------------
module vga_sync_generator
    import vga_timing_pkg::*;
#(
    parameter int   H_VISIBLE = VGA_H_VISIBLE,
    parameter int   H_FRONT   = VGA_H_FRONT,
    parameter int   H_SYNC    = VGA_H_SYNC,
    parameter int   H_BACK    = VGA_H_BACK,
    parameter int   V_VISIBLE = VGA_V_VISIBLE,
    parameter int   V_FRONT   = VGA_V_FRONT,
    parameter int   V_SYNC    = VGA_V_SYNC,
    parameter int   V_BACK    = VGA_V_BACK,
    parameter logic HSYNC_POL = 1'b1,
    parameter logic VSYNC_POL = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pix_en,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [11:0] h_count,
    output logic [10:0] v_count,
    output logic        line_start,
    output logic        frame_start
);

    localparam int H_TOTAL = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

    if (H_TOTAL > 4096 || V_TOTAL > 2048) begin : g_bad_total
        $fatal(1, "vga_sync_generator: H_TOTAL/V_TOTAL exceed counter width");
    end
    if (H_VISIBLE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
        V_VISIBLE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_seg
        $fatal(1, "vga_sync_generator: every segment length must be >= 1");
    end

    logic [11:0] h_pos;
    logic [10:0] v_pos;
    seg_state_t  h_state;
    seg_state_t  v_state;
    logic        h_wrap;
    logic        v_wrap;
    logic        h_at_zero;
    logic        v_at_zero;

    logic        hsync_p1;
    logic        vsync_p1;
    logic        de_p1;
    logic [11:0] h_count_p1;
    logic [10:0] v_count_p1;
    logic        line_start_p1;
    logic        frame_start_p1;

    vga_axis_counter #(
        .VISIBLE (H_VISIBLE),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK),
        .WIDTH   (12)
    ) u_h_axis (
        .clock   (clock),
        .reset   (reset),
        .advance (pix_en),
        .pos     (h_pos),
        .state   (h_state),
        .wrap    (h_wrap)
    );

    vga_axis_counter #(
        .VISIBLE (V_VISIBLE),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK),
        .WIDTH   (11)
    ) u_v_axis (
        .clock   (clock),
        .reset   (reset),
        .advance (h_wrap),
        .pos     (v_pos),
        .state   (v_state),
        .wrap    (v_wrap)
    );

    // Origin flags track "position is 0" from the wrap strobes, so the
    // pulse decode needs no wide zero compare on the counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            h_at_zero <= 1'b1;
            v_at_zero <= 1'b1;
        end else begin
            if (pix_en) begin
                h_at_zero <= h_wrap;
            end
            if (h_wrap) begin
                v_at_zero <= v_wrap;
            end
        end
    end

    // ---- stage p1: decode current position into registered outputs ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hsync_p1       <= ~HSYNC_POL;
            vsync_p1       <= ~VSYNC_POL;
            de_p1          <= 1'b0;
            h_count_p1     <= '0;
            v_count_p1     <= '0;
            line_start_p1  <= 1'b0;
            frame_start_p1 <= 1'b0;
        end else if (pix_en) begin
            hsync_p1       <= (h_state == SEG_SYNC) ? HSYNC_POL : ~HSYNC_POL;
            vsync_p1       <= (v_state == SEG_SYNC) ? VSYNC_POL : ~VSYNC_POL;
            de_p1          <= (h_state == SEG_ACTIVE) && (v_state == SEG_ACTIVE);
            h_count_p1     <= h_pos;
            v_count_p1     <= v_pos;
            line_start_p1  <= h_at_zero;
            frame_start_p1 <= h_at_zero && v_at_zero;
        end else begin
            // Pulses never stretch across idle clocks; everything else holds.
            line_start_p1  <= 1'b0;
            frame_start_p1 <= 1'b0;
        end
    end

    assign hsync       = hsync_p1;
    assign vsync       = vsync_p1;
    assign de          = de_p1;
    assign h_count     = h_count_p1;
    assign v_count     = v_count_p1;
    assign line_start  = line_start_p1;
    assign frame_start = frame_start_p1;

endmodule

// File: tb/tb_vga_sync_generator.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_generator
// Self-checking bench for vga_sync_generator using a reduced geometry so
// several whole frames fit in a short run. The reference derives every
// output from a single count of enabled ticks since reset.
// ---------------------------------------------------------------------------
module tb_vga_sync_generator;

    localparam int HV = 20, HF = 3, HS = 4, HB = 5, HT = HV + HF + HS + HB;
    localparam int VV = 10, VF = 2, VS = 3, VB = 2, VT = VV + VF + VS + VB;
    localparam logic HPOL = 1'b1;
    localparam logic VPOL = 1'b1;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        pix_en = 1'b0;
    logic        hsync, vsync, de, line_start, frame_start;
    logic [11:0] h_count;
    logic [10:0] v_count;

    vga_sync_generator #(
        .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
        .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
        .HSYNC_POL (HPOL), .VSYNC_POL (VPOL)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .pix_en      (pix_en),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .h_count     (h_count),
        .v_count     (v_count),
        .line_start  (line_start),
        .frame_start (frame_start)
    );

    always #10 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // {hsync, vsync, de, line_start, frame_start, h_count, v_count}
    localparam logic [27:0] RESET_VEC = {~HPOL, ~VPOL, 1'b0, 1'b0, 1'b0, 12'd0, 11'd0};

    function automatic logic [27:0] expected_at(input int unsigned t);
        int  h, v;
        logic hs, vs, d;
        h  = int'(t % HT);
        v  = int'((t / HT) % VT);
        hs = (h >= HV + HF && h < HV + HF + HS) ? HPOL : ~HPOL;
        vs = (v >= VV + VF && v < VV + VF + VS) ? VPOL : ~VPOL;
        d  = (h < HV) && (v < VV);
        return {hs, vs, d, (h == 0), (h == 0 && v == 0), 12'(h), 11'(v)};
    endfunction

    int unsigned ticks = 0;
    logic [27:0] exp_vec = RESET_VEC;
    int de_cnt = 0, gap = 0, hs_cnt = 0, vs_cnt = 0;
    bit have_frame = 0, have_line = 0;

    function automatic logic [27:0] observed();
        return {hsync, vsync, de, line_start, frame_start, h_count, v_count};
    endfunction

    // Called just after a negedge: apply enable, let one clock pass, compare.
    task automatic step(input logic en);
        pix_en = en;
        @(posedge clock);
        if (en) begin
            exp_vec = expected_at(ticks);
            ticks++;
        end else begin
            exp_vec[24] = 1'b0;
            exp_vec[23] = 1'b0;
        end
        #1;
        check("outputs", 64'(observed()), 64'(exp_vec));
        if (en) begin
            if (frame_start) begin
                if (have_frame) begin
                    check("frame_ticks", 64'(gap), 64'(HT * VT));
                    check("de_ticks_per_frame", 64'(de_cnt), 64'(HV * VV));
                    check("vsync_ticks_per_frame", 64'(vs_cnt), 64'(HT * VS));
                end
                have_frame = 1;
                gap = 0; de_cnt = 0; vs_cnt = 0;
            end
            if (line_start) begin
                if (have_line) check("hsync_ticks_per_line", 64'(hs_cnt), 64'(HS));
                have_line = 1;
                hs_cnt = 0;
            end
            gap++;
            if (de) de_cnt++;
            if (hsync == HPOL) hs_cnt++;
            if (vsync == VPOL) vs_cnt++;
        end
        @(negedge clock);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check("reset_values", 64'(observed()), 64'(RESET_VEC));
        reset = 1'b0;

        // Continuous pixel rate: a little over two frames.
        for (int i = 0; i < 2 * HT * VT + 40; i++) step(1'b1);

        // Enable every other clock.
        for (int i = 0; i < 2 * HT * VT + 40; i++) step(logic'(i % 2 == 0));

        // Random enable pattern.
        for (int i = 0; i < 600; i++) step(logic'($urandom_range(0, 1)));

        // Asynchronous reset mid-frame, away from any clock edge.
        #3 reset = 1'b1;
        #1 check("async_reset", 64'(observed()), 64'(RESET_VEC));
        pix_en = 1'b1;
        @(posedge clock);
        #1 check("reset_hold", 64'(observed()), 64'(RESET_VEC));
        @(negedge clock);
        reset = 1'b0;
        ticks = 0;
        exp_vec = RESET_VEC;
        have_frame = 0;
        have_line = 0;

        // Restart from the origin, then random enables across more than a frame.
        step(1'b1);
        check("restart_origin", 64'(observed()), 64'(expected_at(0)));
        for (int i = 0; i < HT * VT * 2; i++) step(logic'($urandom_range(0, 3) != 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
